// File: rtl/imem_read_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_read_port_if
//  Description : Bundles the fetch request/response handshake, the branch
//                redirect flush and the program loader write port of the
//                instruction-memory read port.
//                  req_valid/req_addr/req_ready       fetch request channel
//                  resp_valid/resp_ready/resp_data/
//                  resp_addr/resp_err                 response channel
//                  flush                              drop in-flight responses
//                  wr_en/wr_index/wr_data             loader write port
//                master: fetch stage / loader side.
//                slave : memory responder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_read_port_if #(
    parameter int DEPTH_WORDS = 1024
);
    localparam int c_IW = $clog2(DEPTH_WORDS);

    logic            req_valid;
    logic [31:0]     req_addr;
    logic            req_ready;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic [31:0]     resp_addr;
    logic            resp_err;
    logic            flush;
    logic            wr_en;
    logic [c_IW-1:0] wr_index;
    logic [31:0]     wr_data;

    modport master (
        output req_valid, req_addr, resp_ready, flush, wr_en, wr_index, wr_data,
        input  req_ready, resp_valid, resp_data, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, wr_en, wr_index, wr_data,
        output req_ready, resp_valid, resp_data, resp_addr, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : imem_read_port
//  Description : Instruction-memory responder for the fetch stage. Accepts
//                word fetches, reads a DEPTH_WORDS x 32 program memory and
//                returns the instruction word LATENCY cycles after accept
//                through an in-order response queue with full backpressure.
//                Misaligned or out-of-range fetches return resp_err=1 with
//                zero data and the same latency. flush drops everything in
//                flight except a request accepted in the flush cycle.
//                Ports:
//                  clk  - clock
//                  rst  - asynchronous active-high reset
//                  bus  - imem_read_port_if.slave (request, response,
//                         flush and loader write signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_read_port #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    imem_read_port_if.slave bus
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int c_IW = $clog2(DEPTH_WORDS);   // word index width
    localparam int c_QD = LATENCY + 1;           // response queue depth
    localparam int c_PW = $clog2(c_QD);          // queue pointer width
    localparam int c_CW = $clog2(2 * c_QD + 1);  // fits in_flight + queued

    // ------------------------------------------------------------------
    // Program memory (never reset)
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            r_mem[bus.wr_index] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [31:0]     w_offset;
    logic            w_misaligned;
    logic            w_below;
    logic            w_beyond;
    logic            w_err;
    logic [c_IW-1:0] w_idx;
    logic            w_accept;

    always_comb begin
        w_offset     = bus.req_addr - ADDR_BASE;
        w_misaligned = (bus.req_addr[1:0] != 2'b00);
        w_below      = (bus.req_addr < ADDR_BASE);
        // idx >= DEPTH_WORDS exactly when any offset bit above the word
        // index field is set (DEPTH_WORDS is a power of two).
        w_beyond     = (w_offset[31:c_IW+2] != '0);
        w_err        = w_misaligned | w_below | w_beyond;
        w_idx        = w_offset[c_IW+1:2];
    end

    // Byte-offset bits of the subtraction carry no information here.
    logic w_unused_offset_lsbs;
    assign w_unused_offset_lsbs = ^w_offset[1:0];

    assign w_accept = bus.req_valid & bus.req_ready;

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 is loaded at the accept edge with the
    // memory word (old data on a same-cycle write, since the memory
    // update is non-blocking). It never stalls: the occupancy limit on
    // req_ready guarantees the queue has a slot for every stage.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] r_pv;
    logic [31:0]        r_pd [LATENCY];
    logic [31:0]        r_pa [LATENCY];
    logic               r_pe [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
        end else begin
            // A request accepted in the flush cycle is the redirect
            // target and survives the flush.
            r_pv[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= bus.flush ? 1'b0 : r_pv[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pd[0] <= w_err ? 32'h0 : r_mem[w_idx];
            r_pa[0] <= bus.req_addr;
            r_pe[0] <= w_err;
        end
        for (int i = 1; i < LATENCY; i++) begin
            r_pd[i] <= r_pd[i-1];
            r_pa[i] <= r_pa[i-1];
            r_pe[i] <= r_pe[i-1];
        end
    end

    logic [c_CW-1:0] w_inflight;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + c_CW'(r_pv[i]);
        end
    end

    // ------------------------------------------------------------------
    // Response queue (circular, c_QD entries)
    // ------------------------------------------------------------------
    logic [31:0]     r_qd [c_QD];
    logic [31:0]     r_qa [c_QD];
    logic            r_qe [c_QD];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_resp_valid;
    logic [c_CW-1:0] w_occupancy;

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_PW'(c_QD - 1)) ? '0 : p + c_PW'(1);
    endfunction

    assign w_resp_valid = (r_count != '0);
    assign w_push       = r_pv[LATENCY-1];
    assign w_pop        = w_resp_valid & bus.resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            // Whatever pops this cycle is consumed; everything else,
            // including the entry arriving from the pipeline, is dropped.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= f_next(r_tail);
            end
            if (w_pop) begin
                r_head <= f_next(r_head);
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qd[r_tail] <= r_pd[LATENCY-1];
            r_qa[r_tail] <= r_pa[LATENCY-1];
            r_qe[r_tail] <= r_pe[LATENCY-1];
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    // The slot freed by a pop at this edge is credited immediately so a
    // consumer with resp_ready=1 sees one fetch per cycle; without the
    // credit the steady state (LATENCY in flight + 1 queued) would block.
    assign w_occupancy   = w_inflight + r_count - c_CW'(w_pop);
    assign bus.req_ready = !rst && (w_occupancy < c_CW'(c_QD));

    // Payload is forced to zero whenever nothing is presented, which also
    // gives the all-zero reset state without resetting the queue storage.
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = w_resp_valid ? r_qd[r_head] : 32'h0;
    assign bus.resp_addr  = w_resp_valid ? r_qa[r_head] : 32'h0;
    assign bus.resp_err   = w_resp_valid ? r_qe[r_head] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imem_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_read_port
//  Description : Self-checking bench for imem_read_port. Expected responses
//                are queued when a request is accepted and compared in
//                order as the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_read_port;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    imem_read_port_if #(.DEPTH_WORDS(DEPTH)) bus ();

    imem_read_port #(
        .ADDR_BASE   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model_mem [DEPTH];
    int          checks    = 0;
    int          failures  = 0;
    int          accepts   = 0;
    int          delivered = 0;
    int          mark;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        int   idx;
        e.addr = a;
        e.err  = (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(4 * DEPTH));
        idx    = int'((a - BASE) >> 2);
        e.data = e.err ? 32'h0 : model_mem[idx];
        return e;
    endfunction

    // One clock of stimulus: drive after the edge, decide acceptance from
    // req_ready mid-cycle (after the monitor), then apply the loader write
    // to the model so a same-cycle fetch sees the old word.
    task automatic drive(input logic v, input logic [31:0] a, input logic rr,
                         input logic fl, input logic we, input logic [9:0] wi,
                         input logic [31:0] wd);
        @(posedge clk); #1;
        bus.req_valid  = v;
        bus.req_addr   = a;
        bus.resp_ready = rr;
        bus.flush      = fl;
        bus.wr_en      = we;
        bus.wr_index   = wi;
        bus.wr_data    = wd;
        @(negedge clk); #1;
        if (fl) sb.delete();
        if (v && bus.req_ready) begin
            sb.push_back(model(a));
            accepts++;
        end
        if (we) model_mem[wi] = wd;
    endtask

    task automatic fetch(input logic [31:0] a, input logic rr);
        drive(1'b1, a, rr, 1'b0, 1'b0, 10'd0, 32'h0);
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 32'h0, rr, 1'b0, 1'b0, 10'd0, 32'h0);
    endtask

    task automatic load(input logic [9:0] wi, input logic [31:0] wd);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, wi, wd);
    endtask

    // Response monitor: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.resp_valid && bus.resp_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_resp observed addr=%h expected no response", bus.resp_addr);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("resp_addr", bus.resp_addr, mon_e.addr);
                chk("resp_data", bus.resp_data, mon_e.data);
                chk("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
                delivered++;
            end
        end
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.resp_ready = 1'b0;
        bus.flush      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_index   = 10'd0;
        bus.wr_data    = 32'h0;

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_data",  bus.resp_data,       32'h0);
        chk("rst_resp_addr",  bus.resp_addr,       32'h0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- preload ----------------
        load(10'd0,    32'hDEADBEEF);
        chk("ready_after_rst", 32'(bus.req_ready), 32'h1);
        load(10'd1,    32'h00000013);
        load(10'd2,    32'hCAFE0002);
        load(10'd3,    32'hCAFE0003);
        load(10'd4,    32'hCAFE0004);
        load(10'd5,    32'h22222222);
        load(10'd1023, 32'h0BADF00D);

        // ---------------- back-to-back fetch, latency ----------------
        fetch(32'h3000, 1'b1);
        fetch(32'h3004, 1'b1);
        idle(1'b1);
        chk("lat_not_early", 32'(bus.resp_valid), 32'h0);
        idle(1'b1);
        chk("lat_first_valid", 32'(bus.resp_valid), 32'h1);
        chk("lat_first_addr",  bus.resp_addr,       32'h3000);
        idle(1'b1);
        chk("lat_second_valid", 32'(bus.resp_valid), 32'h1);
        chk("lat_second_addr",  bus.resp_addr,       32'h3004);
        idle(1'b1);
        chk("lat_drained", 32'(bus.resp_valid), 32'h0);

        // ---------------- backpressure ----------------
        mark = accepts;
        fetch(32'h3008, 1'b0);
        fetch(32'h300C, 1'b0);
        fetch(32'h3010, 1'b0);
        fetch(32'h3000, 1'b0);
        chk("bp_ready_low", 32'(bus.req_ready), 32'h0);
        fetch(32'h3000, 1'b0);
        chk("bp_accepts", 32'(accepts - mark), 32'd3);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("bp_hold_valid", 32'(bus.resp_valid), 32'h1);
            chk("bp_hold_addr",  bus.resp_addr,       32'h3008);
            chk("bp_hold_data",  bus.resp_data,       32'hCAFE0002);
        end
        repeat (4) idle(1'b1);
        chk("bp_all_delivered", 32'(sb.size()), 32'h0);

        // ---------------- error responses, full throughput ----------------
        mark = accepts;
        fetch(32'h3002, 1'b1);
        fetch(32'h2FFC, 1'b1);
        fetch(32'h4000, 1'b1);
        fetch(32'hFFFFFFFC, 1'b1);
        fetch(32'h3FFC, 1'b1);
        chk("err_throughput", 32'(accepts - mark), 32'd5);
        repeat (5) idle(1'b1);
        chk("err_all_delivered", 32'(sb.size()), 32'h0);

        // ---------------- flush with redirect ----------------
        mark = delivered;
        fetch(32'h3000, 1'b1);
        fetch(32'h3004, 1'b1);
        drive(1'b1, 32'h3008, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0);
        idle(1'b1);
        chk("flush_valid_low", 32'(bus.resp_valid), 32'h0);
        repeat (4) idle(1'b1);
        chk("flush_one_resp", 32'(delivered - mark), 32'd1);

        // ---------------- read-first write collision ----------------
        drive(1'b1, 32'h3014, 1'b1, 1'b0, 1'b1, 10'd5, 32'h11111111);
        fetch(32'h3014, 1'b1);
        repeat (4) idle(1'b1);
        chk("wr_all_delivered", 32'(sb.size()), 32'h0);

        // ---------------- asynchronous reset mid-stream ----------------
        fetch(32'h3000, 1'b0);
        fetch(32'h3004, 1'b0);
        fetch(32'h3008, 1'b0);
        idle(1'b0);
        chk("prerst_valid", 32'(bus.resp_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("async_rst_ready", 32'(bus.req_ready),  32'h0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
        repeat (4) idle(1'b1);
        fetch(32'h3004, 1'b1);
        repeat (4) idle(1'b1);

        // 2 + 3 + 5 + 1 + 2 + 1 responses over the whole run
        chk("total_delivered", 32'(delivered), 32'd14);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
